// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_serial_arbiter slice.
// Holds the channel FSM state enum, a clog2 helper clamped to a minimum of one bit,
// and the even-parity helper used when PISO_ARB_PARITY_EN is defined.
package piso_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   // Widest word the parity helper accepts; narrower words are zero-extended,
   // which leaves the XOR unchanged.
   localparam int PARITY_MAX_W = 256;

   // ceil(log2(n)) with a floor of one bit, so that a counter or an index is never zero-width.
   function automatic int id_width(input int n);
      if (n <= 2) return 1;
      return $clog2(n);
   endfunction

   // Even parity bit: makes the total count of ones (word plus parity) even.
   function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] w);
      return ^w;
   endfunction

endpackage

// File: rtl/piso_shift.sv
// Loadable right shifter feeding the serial line, LSB first, zero fill.
// Latency: a loaded word's bit 0 is on bit_out the cycle after load; one bit per shift.
// Backpressure: none, the owner decides when to load and shift.
// Ports: clk, reset (sync, active-high), load/load_data (parallel load, wins over shift),
//        shift (advance one bit), bit_out (current LSB).
module piso_shift
   import piso_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift,
   output logic             bit_out
);

   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load) begin
         sr_d = load_data;
      end else if (shift) begin
         sr_d = {1'b0, sr_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign bit_out = sr_q[0];

endmodule

// File: rtl/piso_serial_arbiter.sv
// Round-robin arbiter sharing one PISO serial channel between NUM_REQ parallel producers.
// Latency: word bit 0 on dout the cycle after the accept edge, one bit per cycle, LSB first.
// Backpressure: req_ready is combinational, one-hot, and only asserted in IDLE; producers hold data.
// Ports: clk, reset (sync, active-high), req_valid/req_data/req_ready (per-requester handshake,
//        requester i at req_data[i*DATA_WIDTH +: DATA_WIDTH]), dout/dout_valid/dout_first/dout_last
//        (serial frame), grant_id (owner of current/last frame), busy (SHIFT or GAP).
// Build option: define PISO_ARB_PARITY_EN to append an even-parity bit to every frame.
module piso_serial_arbiter
   import piso_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 16,
   parameter int GAP_CYCLES = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          dout,
   output logic                          dout_valid,
   output logic                          dout_first,
   output logic                          dout_last,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy
);

   localparam int ID_W = id_width(NUM_REQ);
   localparam int SW   = ID_W + 1;
`ifdef PISO_ARB_PARITY_EN
   localparam int FRAME_LEN = DATA_WIDTH + 1;
`else
   localparam int FRAME_LEN = DATA_WIDTH;
`endif
   // Clamped so the comparison below stays legal when there is no gap state.
   localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   // One counter serves both the bit index in SHIFT and the idle count in GAP.
   localparam int CNT_MAX  = (FRAME_LEN - 1 > GAP_LAST) ? FRAME_LEN - 1 : GAP_LAST;
   localparam int CNT_W    = id_width(CNT_MAX + 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   grant_q, grant_d;

   logic              sel_found;
   logic [ID_W-1:0]   sel_idx;
   logic [SW-1:0]     cand;
   logic [DATA_WIDTH-1:0] sel_word;
   logic              load;
   logic              shift;
   logic              shift_bit;
   logic              data_bit;

   // Search from the pointer upward, wrapping, and take the first valid requester.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, ptr_q} + SW'(i);
         if (cand >= SW'(NUM_REQ)) begin
            cand = cand - SW'(NUM_REQ);
         end
         if (!sel_found && req_valid[cand[ID_W-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = cand[ID_W-1:0];
         end
      end
   end

   always_comb begin
      sel_word = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel_idx == ID_W'(i)) begin
            sel_word = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == ST_IDLE && !reset && sel_found) begin
         req_ready[sel_idx] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      load    = 1'b0;
      shift   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // In IDLE a found requester is exactly the one seeing ready, so this is the transfer.
            if (sel_found) begin
               load    = 1'b1;
               grant_d = sel_idx;
               ptr_d   = (sel_idx == ID_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            shift = 1'b1;
            if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
               cnt_d   = '0;
               state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt_q == CNT_W'(GAP_LAST)) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
      end
   end

   piso_shift #(
      .WIDTH (DATA_WIDTH)
   ) u_shift (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .load_data (sel_word),
      .shift     (shift),
      .bit_out   (shift_bit)
   );

`ifdef PISO_ARB_PARITY_EN
   logic par_q;

   // Parity is captured with the word; the shifter is empty by the time it is sent.
   always_ff @(posedge clk) begin
      if (reset) begin
         par_q <= 1'b0;
      end else if (load) begin
         par_q <= even_parity(PARITY_MAX_W'(sel_word));
      end
   end

   assign data_bit = (cnt_q == CNT_W'(DATA_WIDTH)) ? par_q : shift_bit;
`else
   assign data_bit = shift_bit;
`endif

   assign dout_valid = (state_q == ST_SHIFT);
   assign dout       = dout_valid & data_bit;
   assign dout_first = dout_valid && (cnt_q == '0);
   assign dout_last  = dout_valid && (cnt_q == CNT_W'(FRAME_LEN - 1));
   assign grant_id   = grant_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_piso_serial_arbiter.sv
// Bench for piso_serial_arbiter: random and directed producers, a frame-level reference model
// that predicts accepts and serial bits, and a monitor that pops the expected bit stream.
module tb_piso_serial_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int G  = 1;
`ifdef PISO_ARB_PARITY_EN
   localparam int FL = DW + 1;
`else
   localparam int FL = DW;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [NR-1:0]     req_valid;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic              dout, dout_valid, dout_first, dout_last, busy;
   logic [1:0]        grant_id;

   always #5 clk = ~clk;

   piso_serial_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .GAP_CYCLES (G)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_first (dout_first),
      .dout_last  (dout_last),
      .grant_id   (grant_id),
      .busy       (busy)
   );

   typedef struct packed {
      logic       b;
      logic       f;
      logic       l;
      logic [1:0] id;
   } exp_t;

   exp_t          exp_q[$];
   int            checks = 0;
   int            errors = 0;
   bit            mon_en = 0;

   // Model state: pending word per requester, rotating priority, cycle when the channel is free.
   bit            pend_v[NR];
   logic [DW-1:0] pend_w[NR];
   int            ptr = 0;
   int            free_at = 0;
   int            cyc = 0;
   int            last_acc = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // One clock cycle: drive producers, predict accept, check handshake, advance the model.
   task automatic tick();
      logic [NR-1:0] exp_ready;
      int            sel;
      bit            took;
      logic          rst_now;
      exp_t          e;
      for (int i = 0; i < NR; i++) begin
         req_valid[i]          = pend_v[i];
         req_data[i*DW +: DW]  = pend_w[i];
      end
      #1;
      rst_now   = reset;
      exp_ready = '0;
      took      = 0;
      sel       = 0;
      if (!rst_now && cyc >= free_at) begin
         for (int k = 0; k < NR; k++) begin
            int j = (ptr + k) % NR;
            if (!took && pend_v[j]) begin
               took = 1;
               sel  = j;
            end
         end
      end
      if (took) exp_ready[sel] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(cyc < free_at));
      if (took) begin
         for (int k = 0; k < FL; k++) begin
            e.b  = (k < DW) ? pend_w[sel][k] : ^pend_w[sel];
            e.f  = (k == 0);
            e.l  = (k == FL - 1);
            e.id = 2'(sel);
            exp_q.push_back(e);
         end
         ptr      = (sel + 1) % NR;
         free_at  = cyc + FL + G + 1;
         last_acc = cyc;
      end
      @(posedge clk);
      if (took) pend_v[sel] = 0;
      if (rst_now) begin
         // The in-flight frame is abandoned; nothing more of it may appear.
         exp_q.delete();
         ptr     = 0;
         free_at = cyc + 1;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_idle();
      int  n = 0;
      bit  pending;
      do begin
         tick();
         n++;
         pending = 0;
         for (int i = 0; i < NR; i++) if (pend_v[i]) pending = 1;
      end while ((cyc < free_at || pending) && n < 400);
      if (cyc < free_at || pending) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout cyc=%0d: channel still busy or requests pending after %0d cycles", cyc, n);
      end
   endtask

   task automatic refill(input int prob_den);
      for (int i = 0; i < NR; i++) begin
         if (!pend_v[i] && $urandom_range(prob_den - 1) == 0) begin
            pend_v[i] = 1;
            pend_w[i] = DW'($urandom);
         end
      end
   endtask

   // Monitor: every valid serial bit must be the next expected one; idle cycles must be quiet.
   initial begin
      exp_t e;
      wait (mon_en);
      forever begin
         @(negedge clk);
         if (dout_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("dout_valid_unexpected", 32'(dout_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("dout", 32'(dout), 32'(e.b));
               chk("dout_first", 32'(dout_first), 32'(e.f));
               chk("dout_last", 32'(dout_last), 32'(e.l));
               chk("grant_id", 32'(grant_id), 32'(e.id));
            end
         end else begin
            chk("idle_outputs", {29'd0, dout, dout_first, dout_last}, 32'd0);
         end
      end
   end

   initial begin
      int acc;
      for (int i = 0; i < NR; i++) begin
         pend_v[i] = 0;
         pend_w[i] = '0;
      end
      req_valid = '0;
      req_data  = '0;
      reset     = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_dout_valid", 32'(dout_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_dout_last", 32'(dout_last), 32'd0);
      tick();
      reset  = 1'b0;
      mon_en = 1;

      // Single request from requester 1.
      pend_v[1] = 1;
      pend_w[1] = 8'hA5;
      run_idle();

      // All four requesting continuously.
      for (int c = 0; c < 60; c++) begin
         refill(1);
         tick();
      end
      run_idle();

      // Pointer wrap: grant 3, then 0 and 2 compete.
      pend_v[3] = 1;
      pend_w[3] = 8'h3C;
      tick();
      pend_v[0] = 1;
      pend_w[0] = 8'h81;
      pend_v[2] = 1;
      pend_w[2] = 8'h5A;
      run_idle();

      // Reset while bit 3 of a frame is on the line.
      pend_v[2] = 1;
      pend_w[2] = 8'hF0;
      last_acc  = -1;
      tick();
      acc = last_acc;
      if (acc < 0) begin
         checks++;
         errors++;
         $display("FAIL reset_setup cyc=%0d: frame was not accepted", cyc);
      end
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_dout_valid", 32'(dout_valid), 32'd0);
      chk("abort_dout_last", 32'(dout_last), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_grant_id", 32'(grant_id), 32'd0);
      chk("abort_dout", 32'(dout), 32'd0);
      for (int i = 0; i < NR; i++) begin
         pend_v[i] = 1;
         pend_w[i] = DW'($urandom);
      end
      run_idle();

      // Randomized traffic.
      for (int c = 0; c < 1500; c++) begin
         refill(3);
         tick();
      end
      run_idle();
      repeat (2) tick();

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/piso_serial_arbiter.md
Name: piso_serial_arbiter

Overview:
- Shares one parallel-in, serial-out shift channel between NUM_REQ requesters.
- Round-robin arbiter accepts one parallel word per frame over a valid/ready handshake.
- Loads the accepted word into the shifter and sequences LSB-first serialization.
- Frame markers and the owning requester id are output alongside the serial data.
- Sits between parallel producers and a single-bit serial link.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 16, bits per frame word (>=2).
- GAP_CYCLES, 1, idle cycles forced between frames (>=0).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester word available.
- req_data  input  NUM_REQ*DATA_WIDTH  flat words; requester i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- dout  output  1  serial data bit.
- dout_valid  output  1  dout carries a frame bit.
- dout_first  output  1  first bit of frame.
- dout_last  output  1  final bit of frame.
- grant_id  output  $clog2(NUM_REQ)  requester owning the current frame.
- busy  output  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, shift register 0, bit counter 0, round-robin pointer 0 (requester 0 has highest priority).
- Reset mid-frame: abort immediately. No dout_last is emitted and the partial word is discarded.
- Reset has priority over all other events.
- States: IDLE, SHIFT, GAP.
- IDLE arbitration:
  - Grant goes to the first asserted req_valid at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready is combinational: high only for the selected requester, only in IDLE, only when not in reset.
  - Transfer occurs when valid && ready at a rising edge. On that edge: latch the word, set grant_id, set pointer = (grant+1) mod NUM_REQ, go to SHIFT.
- SHIFT:
  - Latency: the first bit (word[0]) appears in the cycle after the transfer edge.
  - Bit k appears k cycles later.
  - dout_valid=1 for the whole frame. dout_first=1 on bit 0. dout_last=1 on the final frame bit.
  - After the final bit: go to GAP if GAP_CYCLES>0, else IDLE.
  - With GAP_CYCLES=0, frames are separated by exactly one IDLE cycle (the accept cycle).
- GAP: dout_valid=0 for GAP_CYCLES cycles, then IDLE.
- Outputs when dout_valid=0: dout, dout_first and dout_last are 0. grant_id holds the last owner.
- req_valid changes while not ready are ignored. Requesters hold data until accepted; no data is lost.
- busy=1 in SHIFT and GAP.

Optional Feature:
- Macro: PISO_ARB_PARITY_EN.
- Defined:
  - Frame length is DATA_WIDTH+1.
  - The extra final bit is even parity (XOR of the accepted word).
  - dout_last moves to the parity bit.
- Undefined: frame length is DATA_WIDTH, with no parity logic.

Decomposition:
- Shared package piso_pkg holds:
  - State enum (IDLE, SHIFT, GAP).
  - Function computing clog2-safe id width (min 1).
  - Parity helper function.
- Sub-module piso_shift: loadable DATA_WIDTH shifter.
  - Ports: clk, reset, load, load_data, shift, bit_out.
  - LSB out; zero fill on shift.
- The arbiter/FSM stays in the top module.

Test Plan (NUM_REQ=4, DATA_WIDTH=8, GAP_CYCLES=1 unless stated):
- Single request: req_valid=4'b0010, word 8'hA5 -> grant_id=1. dout sequence 1,0,1,0,0,1,0,1, first on bit 0, last on bit 7. One gap cycle, then IDLE.
- All four requesting continuously -> grants 0,1,2,3,0 in order. Each frame 8 valid bits plus 1 gap plus 1 accept cycle (10-cycle period).
- Pointer wrap: after a grant to 3, requesters 0 and 2 both valid -> requester 0 granted.
- Reset asserted at bit 3 of a frame -> next cycle all outputs 0, no dout_last, state IDLE. Pointer returns to 0 and requester 0 wins the next arbitration.
- GAP_CYCLES=0 build, back-to-back requests -> exactly one dout_valid=0 cycle between frames.
- PISO_ARB_PARITY_EN defined, word 8'h07 -> 9 valid bits, final bit 1, dout_last on bit index 8.
